// File: rtl/exe_mul_ctrl.sv
// Execute-stage sequencer for mul.w / mulh.w / mulh.wu: launches the external multiplier,
// holds operands until it finishes, and hands results (or pass-through values) to the memory stage.
module exe_mul_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    output logic        es_allowin,
    input  logic [9:0]  ds_mul_div_op,
    input  logic [31:0] ds_alu_src1,
    input  logic [31:0] ds_alu_src2,
    input  logic [31:0] ds_alu_result,
    input  logic [4:0]  ds_dest,
    input  logic [31:0] ds_pc,
    output logic        mult,
    output logic [9:0]  mul_div_op,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] mul_result,
    input  logic        mul_done,
    output logic        es_to_ms_valid,
    input  logic        ms_allowin,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic [31:0] es_pc,
    input  logic        flush
);

    // Handshake: a transfer happens on any cycle where the producer's valid and the
    // consumer's allowin are both high at the rising edge; flush vetoes an upstream transfer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   is_mul;
    logic   capture;

    assign is_mul         = |ds_mul_div_op[2:0];
    assign es_allowin     = (state == EMPTY) | ((state == FULL) & ms_allowin);
    assign es_to_ms_valid = (state == FULL);
    assign accept         = ds_to_es_valid & es_allowin & ~flush;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) state_next = is_mul ? BUSY : FULL;
            end
            BUSY: begin
                if (mul_done & ~flush) begin
                    state_next = FULL;
                    capture    = 1'b1;
                end else if (flush & ~mul_done) begin
                    state_next = DRAIN;
                end else if (flush & mul_done) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (flush) begin
                    state_next = EMPTY;
                end else if (ms_allowin) begin
                    if (accept) state_next = is_mul ? BUSY : FULL;
                    else        state_next = EMPTY;
                end
            end
            DRAIN: begin
                // The multiplier cannot be cancelled, so wait out its result before reuse.
                if (mul_done) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            mult       <= 1'b0;
            mul_div_op <= '0;
            alu_src1   <= '0;
            alu_src2   <= '0;
            es_result  <= '0;
            es_dest    <= '0;
            es_pc      <= '0;
        end else begin
            state <= state_next;
            // Registered so the launch pulse lands in the first BUSY cycle only.
            mult  <= accept & is_mul;
            if (accept) begin
                mul_div_op <= ds_mul_div_op;
                alu_src1   <= ds_alu_src1;
                alu_src2   <= ds_alu_src2;
                es_dest    <= ds_dest;
                es_pc      <= ds_pc;
                if (!is_mul) es_result <= ds_alu_result;
            end else if (state_next == EMPTY) begin
                mul_div_op <= '0;
            end
            if (capture) es_result <= mul_result;
        end
    end

endmodule
